serial_uart_bridge: RTL and testbench

- Device-side end of the processor's serial MMIO port: the byte-wide strobe/valid/ready interface that the 0xffff0000 serial window drives.
- Converts that interface to an asynchronous 8N1 UART line pair for the board pins.
- Contains a TX byte FIFO feeding a serializer and a deserializer feeding an RX byte FIFO.
- Sits at top level between the CPU data-memory subsystem and the FPGA UART pins.

---
 rtl/serial_uart_pkg.sv | 21 ++
 rtl/serial_uart_fifo.sv | 52 +++++
 rtl/serial_uart_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_serial_uart_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_uart_pkg.sv
// Shared encodings and constants for the serial MMIO <-> 8N1 UART bridge.
package serial_uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/serial_uart_fifo.sv
// Synchronous byte FIFO with count-based full/empty and a combinational head (zero when empty).
module serial_uart_fifo
  import serial_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push while full is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// CPU serial-window strobe/valid/ready port to 8N1 UART pins, with TX and RX byte FIFOs.
// Optional SERIAL_UART_LOOPBACK_EN feeds the RX synchronizer from the internal uart_tx register.
module serial_uart_bridge
  import serial_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TX_DEPTH     = 4,
  parameter int unsigned RX_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] serial_data_in,
  input  logic       serial_wren_in,
  output logic       serial_ready_out,
  output logic [7:0] serial_data_out,
  output logic       serial_valid_out,
  input  logic       serial_rden_in,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);

  localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 tx_full, tx_empty, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_full, rx_empty, rx_push;

  tx_state_e            tx_state_q, tx_state_d;
  logic [BW-1:0]        tx_baud_q, tx_baud_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 uart_tx_q, uart_tx_d;

  rx_state_e            rx_state_q, rx_state_d;
  logic [BW-1:0]        rx_baud_q, rx_baud_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic [1:0]           rx_sync_q;
  logic                 rx_prev_q, rx_sync, rx_line;
  logic                 rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;

  serial_uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (serial_wren_in && !tx_full),
    .data_i  (serial_data_in),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  serial_uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (rx_push),
    .data_i  (rx_data_q),
    .pop_i   (serial_rden_in),
    .data_o  (serial_data_out),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign serial_ready_out = !tx_full;
  assign serial_valid_out = !rx_empty;
  assign uart_tx          = uart_tx_q;
  assign rx_overrun_out   = rx_ovr_q;
  assign rx_frame_err_out = rx_ferr_q;

`ifdef SERIAL_UART_LOOPBACK_EN
  assign rx_line = uart_tx_q;
`else
  assign rx_line = uart_rx;
`endif

  assign rx_sync = rx_sync_q[1];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_data_d  = tx_head;
          tx_baud_d  = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_baud_d = tx_baud_q + BW'(1);
        end
      end
      TX_DATA: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == BIT_LAST) tx_state_d = TX_STOP;
          else                      tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_baud_d = tx_baud_q + BW'(1);
        end
      end
      default: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          // Back-to-back frames: reload straight into START without an idle bit.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_data_d  = tx_head;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_baud_d = tx_baud_q + BW'(1);
        end
      end
    endcase

    // Line level follows the state one cycle later, so every bit lasts exactly CLKS_PER_BIT.
    case (tx_state_q)
      TX_START: uart_tx_d = 1'b0;
      TX_DATA:  uart_tx_d = tx_data_q[tx_bit_q];
      default:  uart_tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      uart_tx_q  <= IDLE_LEVEL;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      uart_tx_q  <= uart_tx_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync) begin
          rx_baud_d  = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_d = rx_baud_q + BW'(1);
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_data_d[rx_bit_q] = rx_sync;
          rx_baud_d = '0;
          if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_baud_d = rx_baud_q + BW'(1);
        end
      end
      default: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_state_d = RX_IDLE;
          if (!rx_sync)                         rx_ferr_d = 1'b1;
          else if (!rx_full || serial_rden_in)  rx_push   = 1'b1;
          else                                  rx_ovr_d  = 1'b1;
        end else begin
          rx_baud_d = rx_baud_q + BW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync_q  <= {2{IDLE_LEVEL}};
      rx_prev_q  <= IDLE_LEVEL;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx_line};
      rx_prev_q  <= rx_sync;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Randomized bench for serial_uart_bridge against a frame-level reference model.
// Build with SERIAL_UART_LOOPBACK_EN to exercise the loopback path instead of the RX pin.
module tb_serial_uart_bridge;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] serial_data_in = '0;
  logic       serial_wren_in = 1'b0;
  logic       serial_ready_out;
  logic [7:0] serial_data_out;
  logic       serial_valid_out;
  logic       serial_rden_in = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  serial_uart_bridge #(
    .CLKS_PER_BIT (CPB),
    .TX_DEPTH     (DEPTH),
    .RX_DEPTH     (DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .serial_data_in   (serial_data_in),
    .serial_wren_in   (serial_wren_in),
    .serial_ready_out (serial_ready_out),
    .serial_data_out  (serial_data_out),
    .serial_valid_out (serial_valid_out),
    .serial_rden_in   (serial_rden_in),
    .uart_rx          (uart_rx),
    .uart_tx          (uart_tx),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc = 0;

  // TX model: each accepted byte becomes a scheduled frame start (edge index of first low cycle)
  int          fr_start[$];
  logic [7:0]  fr_byte[$];
  int          last_start = -100000;
  int          pop_ptr = 0;
  int          m_cnt = 0;

  // RX model: FIFO contents and sticky flags
  logic [7:0]  rxq[$];
  logic        m_ovr = 1'b0;
  logic        m_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic exp_line(input int e);
    for (int i = 0; i < fr_start.size(); i++) begin
      if (e >= fr_start[i] && e < fr_start[i] + FRAME) begin
        int s;
        logic [7:0] b;
        s = (e - fr_start[i]) / CPB;
        b = fr_byte[i];
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return b[s-1];
      end
    end
    return 1'b1;
  endfunction

  task automatic tx_model_clear();
    fr_start.delete();
    fr_byte.delete();
    last_start = -100000;
    pop_ptr = 0;
    m_cnt = 0;
  endtask

  // One clock of TX traffic: check ready and line, optionally push, advance the model.
  task automatic tx_cycle(input logic wr, input logic [7:0] d);
    logic acc;
    int   st;
    check("tx_ready", {31'b0, serial_ready_out}, {31'b0, (m_cnt < DEPTH)});
    check("tx_line", {31'b0, uart_tx}, {31'b0, exp_line(cyc)});
    acc = wr && (m_cnt < DEPTH);
    serial_wren_in = wr;
    serial_data_in = d;
    tick();
    serial_wren_in = 1'b0;
    if (acc) begin
      st = (cyc + 2 > last_start + FRAME) ? cyc + 2 : last_start + FRAME;
      fr_start.push_back(st);
      fr_byte.push_back(d);
      last_start = st;
      m_cnt++;
    end
    while (pop_ptr < fr_start.size() && fr_start[pop_ptr] - 1 <= cyc) begin
      m_cnt--;
      pop_ptr++;
    end
  endtask

  task automatic rx_check();
    check("rx_valid", {31'b0, serial_valid_out}, {31'b0, (rxq.size() != 0)});
    check("rx_data", {24'b0, serial_data_out}, (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h0);
    check("rx_overrun", {31'b0, rx_overrun_out}, {31'b0, m_ovr});
    check("rx_frame_err", {31'b0, rx_frame_err_out}, {31'b0, m_ferr});
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    for (int s = 0; s < 10; s++) begin
      uart_rx = (s == 0) ? 1'b0 : (s == 9) ? stop : b[s-1];
      repeat (CPB) tick();
    end
    uart_rx = 1'b1;
    repeat (6) tick();
    if (!stop)                  m_ferr = 1'b1;
    else if (rxq.size() < DEPTH) rxq.push_back(b);
    else                        m_ovr = 1'b1;
    rx_check();
  endtask

  task automatic rx_pop();
    check("rx_head", {24'b0, serial_data_out}, (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h0);
    serial_rden_in = 1'b1;
    tick();
    serial_rden_in = 1'b0;
    if (rxq.size() != 0) rxq.delete(0);
    rx_check();
  endtask

  task automatic reset_checks();
    check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("rst_ready", {31'b0, serial_ready_out}, 32'h1);
    check("rst_valid", {31'b0, serial_valid_out}, 32'h0);
    check("rst_data", {24'b0, serial_data_out}, 32'h0);
    check("rst_overrun", {31'b0, rx_overrun_out}, 32'h0);
    check("rst_frame_err", {31'b0, rx_frame_err_out}, 32'h0);
  endtask

  initial begin
    repeat (3) tick();
    reset_checks();
    reset = 1'b1;

`ifdef SERIAL_UART_LOOPBACK_EN
    uart_rx = 1'b0;
    repeat (4) tx_cycle(1'b0, 8'h00);
    tx_cycle(1'b1, 8'h5A);
    repeat (FRAME + 20) tx_cycle(1'b0, 8'h00);
    check("lb_valid", {31'b0, serial_valid_out}, 32'h1);
    check("lb_data", {24'b0, serial_data_out}, 32'h5A);
    check("lb_frame_err", {31'b0, rx_frame_err_out}, 32'h0);
    serial_rden_in = 1'b1;
    tick();
    serial_rden_in = 1'b0;
`endif

    // Single byte from idle, pushed on the 10th cycle after reset release.
    repeat (9) tx_cycle(1'b0, 8'h00);
    tx_cycle(1'b1, 8'hA5);
    repeat (FRAME + 20) tx_cycle(1'b0, 8'h00);

    // Five back-to-back pushes while idle; frames must chain without gaps.
    for (int i = 0; i < 5; i++) tx_cycle(1'b1, 8'(8'h30 + i));
    repeat (5 * FRAME + 20) tx_cycle(1'b0, 8'h00);

    // Random traffic with occasional bursts that hit the full FIFO.
    for (int i = 0; i < 1500; i++) begin
      tx_cycle(($urandom % 16) == 0, 8'($urandom));
    end
    repeat (DEPTH * FRAME + FRAME + 20) tx_cycle(1'b0, 8'h00);

`ifndef SERIAL_UART_LOOPBACK_EN
    uart_rx = 1'b1;
    repeat (5) tick();
    rx_send(8'h3C, 1'b1);
    rx_pop();
    for (int i = 0; i < 5; i++) rx_send(8'(8'h11 * (i + 1)), 1'b1);
    repeat (DEPTH + 1) rx_pop();
    rx_send(8'hA7, 1'b0);
    // Short low pulse must be rejected as a glitch.
    uart_rx = 1'b0;
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (3 * CPB) tick();
    rx_check();
    rx_send(8'h96, 1'b1);
    for (int i = 0; i < 14; i++) begin
      int np;
      rx_send(8'($urandom), ($urandom % 6) != 0);
      np = $urandom % 3;
      repeat (np) rx_pop();
    end
    check("rx_idle_tx_line", {31'b0, uart_tx}, 32'h1);
`endif

    // Asynchronous reset in the middle of a start bit.
    tx_cycle(1'b1, 8'h00);
    repeat (6) tx_cycle(1'b0, 8'h00);
    #2 reset = 1'b0;
    #1;
    check("async_rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("async_rst_valid", {31'b0, serial_valid_out}, 32'h0);
    check("async_rst_ready", {31'b0, serial_ready_out}, 32'h1);
    tx_model_clear();
    rxq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset_checks();
    repeat (2 * FRAME) tx_cycle(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
